// File: rtl/seq_bcd_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// Handshake: a request is taken when start=1 is sampled on a rising edge while
// busy=0; requests seen while busy=1 are dropped (no queueing). The result is
// valid on bcd/sign_out in the single cycle where done=1 and is held afterwards.
interface seq_bcd_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  sign_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  sign_out;
    logic                  state_dbg;   // 0 = IDLE, 1 = SHIFT

    modport master (
        output start, bin, sign_in,
        input  busy, done, bcd, sign_out, state_dbg
    );

    modport slave (
        input  start, bin, sign_in,
        output busy, done, bcd, sign_out, state_dbg
    );
endinterface

// File: rtl/seq_bcd_converter.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble), one
// input bit per clock. A 16-bit magnitude takes 16 shift cycles after the
// capture edge; bcd/sign_out only change on completion.
module seq_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic      clk,
    input  logic      rst,
    seq_bcd_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    bin_sr;
    logic [BCD_W-1:0]    work;
    logic [CNT_W-1:0]    cnt;
    logic                sign_latch;
    logic                busy_r;
    logic                done_r;
    logic [BCD_W-1:0]    bcd_r;
    logic                sign_out_r;

    logic [BCD_W-1:0]    corr;
    logic [BCD_W-1:0]    shifted;

    // Add 3 to every working digit >= 5, then form the next shifted working value.
    always_comb begin
        corr = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5) begin
                corr[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end
        end
        // The top bit of corr is always 0 for a 16-bit input, so dropping it is safe.
        shifted = {corr[BCD_W-2:0], bin_sr[WIDTH-1]};
    end

    // Conversion FSM: capture in IDLE, shift WIDTH times in SHIFT, publish on the last shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bin_sr     <= '0;
            work       <= '0;
            cnt        <= '0;
            sign_latch <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_r      <= '0;
            sign_out_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_sr     <= bus.bin;
                        sign_latch <= bus.sign_in;
                        work       <= '0;
                        cnt        <= '0;
                        busy_r     <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    work   <= shifted;
                    bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        bcd_r      <= shifted;
                        sign_out_r <= sign_latch;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.bcd       = bcd_r;
    assign bus.sign_out  = sign_out_r;
    assign bus.state_dbg = logic'(state);

endmodule

// File: doc/seq_bcd_converter.md
SEQ_BCD_CONVERTER -- requirements
Module: seq_bcd_converter

Interface
REQ-001 Parameter: WIDTH, 16, binary input width; 16 is the only supported value.
REQ-002 Parameter: DIGITS, 5, BCD output digit count; 5 is the only supported value.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request conversion of bin/sign_in; sampled on a rising edge.
REQ-007 bin  input  WIDTH  unsigned magnitude (product register value).
REQ-008 sign_in  input  1  sign flag accompanying bin.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse marking updated bcd/sign_out.
REQ-011 bcd  output  4*DIGITS  packed BCD, digit 4 in [19:16] down to digit 0 in [3:0]; feeds the seven-segment scroller.
REQ-012 sign_out  output  1  sign_in captured with the conversion; feeds the scroller.

Function
REQ-013 Algorithm: shift-add-3 (double dabble), one bit per clock.
REQ-014 FSM states: IDLE, SHIFT only.
REQ-015 IDLE, start=1 at edge E0: capture bin into the binary shift register, sign_in into the sign latch, clear the BCD working register, set bit counter=0, go to SHIFT, busy=1.
REQ-016 IDLE, start=0: hold all registers.
REQ-017 SHIFT, edges E1..E16: per edge, add 3 to each working BCD digit >=5, then shift {BCD working, binary} left 1 bit, counter+1.
REQ-018 Edge E16 (counter reaches WIDTH): load the corrected/shifted result into bcd, load the sign latch into sign_out, set done=1, go to IDLE, busy=0.
REQ-019 Latency: done is high exactly in the cycle between E16 and E17 (16 clocks after the start sample); done clears at E17 unless a new completion occurs.
REQ-020 bcd and sign_out hold their last completed values between completions; they never show intermediate working values.
REQ-021 start while busy=1 (E1..E16, including E16) is ignored; no queueing.
REQ-022 start sampled at E17 (IDLE) is accepted; back-to-back throughput is one conversion per 17 cycles.
REQ-023 Changes on bin/sign_in after E0 do not affect the conversion in progress.
REQ-024 Every BCD digit of bcd is <=9; max input 65535 gives 0x65535; no overflow condition exists.
REQ-025 sign_out is passed through unmodified; a zero magnitude with sign_in=1 still reports sign_out=1 (sign suppression is upstream).

Reset
REQ-026 rst=1 at a rising edge sets state=IDLE, busy=0, done=0, bcd=0, sign_out=0, counter=0, and clears the working registers.
REQ-027 rst has priority over start and over any in-progress conversion; a conversion aborted by reset produces no done pulse.
REQ-028 start sampled in the same edge as rst=1 is discarded.

Verification
REQ-029 Reset, then bin=0, sign_in=0, start at E0 -> busy high E0..E16, done at E16, bcd=0x00000, sign_out=0.
REQ-030 bin=65535, sign_in=0 -> bcd=0x65535 at done; bin=16129 (127*127), sign_in=1 -> bcd=0x16129, sign_out=1.
REQ-031 bin=16384 (128*128) converting; at E5 start again with bin=1 -> ignored; done at E16 with bcd=0x16384, no second done.
REQ-032 rst pulsed at E8 mid-conversion of bin=1234 -> bcd=0, sign_out=0, busy=0, no done; a fresh start of bin=1234 -> bcd=0x01234.
REQ-033 Back-to-back: start held high continuously with bin=99 then bin=100 -> done pulses at E16 and E33, bcd=0x00099 then 0x00100.
REQ-034 Random sweep of 1000 (bin, sign_in) pairs vs. a reference decimal model -> bcd and sign_out match on every done pulse.
